obj_bbox_detect: RTL and testbench

//  Downstream consumer of the timing/pattern generator's DE/HS/VS + RGB stream.

---
 rtl/obj_bbox_detect.sv | 212 +++++++++++++++++++++
 tb/tb_obj_bbox_detect.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/obj_bbox_detect.sv
// obj_bbox_detect: colour-key object detector; accumulates the bounding box and
//   count of matching pixels over one frame and reports them once per frame.
// Latency: O_bbox_valid rises 3 clocks after the edge that first samples VS active.
// Backpressure: none; the block consumes one pixel per I_pxl_clk and never stalls.
// Ports:
//   I_pxl_clk, I_rst (sync, active-high)
//   I_de, I_vs, I_vs_pol (0: VS active-low, 1: VS active-high)
//   I_data_r/g/b  pixel stream
//   I_key_r/g/b, I_tol  colour key and per-channel tolerance
//   O_bbox_valid  1-cycle pulse when a new frame result is presented
//   O_found, O_x_min/O_x_max/O_y_min/O_y_max (inclusive), O_pix_cnt
module obj_bbox_detect #(
  parameter int CW      = 16,
  parameter int MIN_PIX = 16
) (
  input  logic          I_pxl_clk,
  input  logic          I_rst,
  input  logic          I_de,
  input  logic          I_vs,
  input  logic          I_vs_pol,
  input  logic [7:0]    I_data_r,
  input  logic [7:0]    I_data_g,
  input  logic [7:0]    I_data_b,
  input  logic [7:0]    I_key_r,
  input  logic [7:0]    I_key_g,
  input  logic [7:0]    I_key_b,
  input  logic [7:0]    I_tol,
  output logic          O_bbox_valid,
  output logic          O_found,
  output logic [CW-1:0] O_x_min,
  output logic [CW-1:0] O_x_max,
  output logic [CW-1:0] O_y_min,
  output logic [CW-1:0] O_y_max,
  output logic [23:0]   O_pix_cnt
);

  // Magnitude of a difference of two 8-bit values, computed 9 bits wide so
  // that |0 - 255| gives 255 rather than wrapping to 1.
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[8] ? (~s + 9'd1) : s;
  endfunction

  // ---------------- stage 0: registered inputs ----------------
  logic          de_s0, vs_s0, pol_s0;
  logic [7:0]    pix_r_s0, pix_g_s0, pix_b_s0;
  logic [7:0]    key_r_s0, key_g_s0, key_b_s0, tol_s0;
  logic          de_d1, vs_act_d1;
  logic [CW-1:0] x_q, y_q;

  logic          vs_act, vs_edge, de_rise, de_fall;
  logic [CW-1:0] x_cur;

  always_comb begin
    vs_act  = vs_s0 ^ ~pol_s0;
    vs_edge = vs_act & ~vs_act_d1;
    de_rise = de_s0 & ~de_d1;
    de_fall = ~de_s0 & de_d1;
    x_cur   = de_rise ? '0 : x_q + CW'(1);
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      de_s0     <= 1'b0;
      vs_s0     <= 1'b0;
      pol_s0    <= 1'b0;
      pix_r_s0  <= '0;
      pix_g_s0  <= '0;
      pix_b_s0  <= '0;
      key_r_s0  <= '0;
      key_g_s0  <= '0;
      key_b_s0  <= '0;
      tol_s0    <= '0;
      de_d1     <= 1'b0;
      // The zeroed stage-0 registers decode as "VS active" for one cycle;
      // starting the delayed copy high keeps that from looking like an edge.
      vs_act_d1 <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      de_s0     <= I_de;
      vs_s0     <= I_vs;
      pol_s0    <= I_vs_pol;
      pix_r_s0  <= I_data_r;
      pix_g_s0  <= I_data_g;
      pix_b_s0  <= I_data_b;
      key_r_s0  <= I_key_r;
      key_g_s0  <= I_key_g;
      key_b_s0  <= I_key_b;
      tol_s0    <= I_tol;
      de_d1     <= de_s0;
      vs_act_d1 <= vs_act;
      if (de_s0) x_q <= x_cur;
      if (vs_edge)      y_q <= '0;
      else if (de_fall) y_q <= y_q + CW'(1);
    end
  end

  // ---------------- stage 1: per-channel distance ----------------
  logic          de_s1, vse_s1;
  logic [CW-1:0] x_s1, y_s1;
  logic [8:0]    d_r_s1, d_g_s1, d_b_s1;
  logic [7:0]    tol_s1;

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      de_s1  <= 1'b0;
      vse_s1 <= 1'b0;
      x_s1   <= '0;
      y_s1   <= '0;
      d_r_s1 <= '0;
      d_g_s1 <= '0;
      d_b_s1 <= '0;
      tol_s1 <= '0;
    end else begin
      de_s1  <= de_s0;
      vse_s1 <= vs_edge;
      x_s1   <= x_cur;
      y_s1   <= y_q;
      d_r_s1 <= abs_diff(pix_r_s0, key_r_s0);
      d_g_s1 <= abs_diff(pix_g_s0, key_g_s0);
      d_b_s1 <= abs_diff(pix_b_s0, key_b_s0);
      tol_s1 <= tol_s0;
    end
  end

  // ---------------- stage 2: match decision ----------------
  logic          match_s2, fe_s2;
  logic [CW-1:0] x_s2, y_s2;

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      match_s2 <= 1'b0;
      fe_s2    <= 1'b0;
      x_s2     <= '0;
      y_s2     <= '0;
    end else begin
      match_s2 <= de_s1 & (d_r_s1 <= {1'b0, tol_s1})
                        & (d_g_s1 <= {1'b0, tol_s1})
                        & (d_b_s1 <= {1'b0, tol_s1});
      fe_s2    <= vse_s1;
      x_s2     <= x_s1;
      y_s2     <= y_s1;
    end
  end

  // ---------------- accumulate and report ----------------
  logic [23:0]   acc_cnt;
  logic [CW-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic          armed;
  logic          acc_found;

  assign acc_found = (acc_cnt >= 24'(MIN_PIX));

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      acc_cnt      <= '0;
      acc_xmin     <= '0;
      acc_xmax     <= '0;
      acc_ymin     <= '0;
      acc_ymax     <= '0;
      armed        <= 1'b0;
      O_bbox_valid <= 1'b0;
      O_found      <= 1'b0;
      O_x_min      <= '0;
      O_x_max      <= '0;
      O_y_min      <= '0;
      O_y_max      <= '0;
      O_pix_cnt    <= '0;
    end else begin
      O_bbox_valid <= 1'b0;
      if (fe_s2) begin
        // The first frame end after reset only closes a partial frame.
        if (armed) begin
          O_bbox_valid <= 1'b1;
          O_found      <= acc_found;
          O_pix_cnt    <= acc_cnt;
          O_x_min      <= acc_found ? acc_xmin : '0;
          O_x_max      <= acc_found ? acc_xmax : '0;
          O_y_min      <= acc_found ? acc_ymin : '0;
          O_y_max      <= acc_found ? acc_ymax : '0;
        end
        armed <= 1'b1;
        // A pixel coinciding with frame end opens the new frame.
        if (match_s2) begin
          acc_cnt  <= 24'd1;
          acc_xmin <= x_s2;
          acc_xmax <= x_s2;
          acc_ymin <= y_s2;
          acc_ymax <= y_s2;
        end else begin
          acc_cnt  <= '0;
        end
      end else if (match_s2) begin
        if (acc_cnt == '0) begin
          acc_xmin <= x_s2;
          acc_xmax <= x_s2;
          acc_ymin <= y_s2;
          acc_ymax <= y_s2;
        end else begin
          if (x_s2 < acc_xmin) acc_xmin <= x_s2;
          if (x_s2 > acc_xmax) acc_xmax <= x_s2;
          if (y_s2 < acc_ymin) acc_ymin <= y_s2;
          if (y_s2 > acc_ymax) acc_ymax <= y_s2;
        end
        if (acc_cnt != 24'hFFFFFF) acc_cnt <= acc_cnt + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_obj_bbox_detect.sv
// Directed bench for obj_bbox_detect: 64x32 frames with 8-cycle line blanking
// and a 5-line vertical blank carrying a 1-line VS pulse.
module tb_obj_bbox_detect;
  localparam int CW = 16;
  localparam int W  = 64;
  localparam int H  = 32;
  localparam int HB = 8;
  localparam int LL = W + HB;

  logic          I_pxl_clk = 1'b0;
  logic          I_rst, I_de, I_vs, I_vs_pol;
  logic [7:0]    I_data_r, I_data_g, I_data_b;
  logic [7:0]    I_key_r, I_key_g, I_key_b, I_tol;
  logic          O_bbox_valid, O_found;
  logic [CW-1:0] O_x_min, O_x_max, O_y_min, O_y_max;
  logic [23:0]   O_pix_cnt;

  obj_bbox_detect #(.CW(CW), .MIN_PIX(16)) dut (
    .I_pxl_clk(I_pxl_clk), .I_rst(I_rst), .I_de(I_de), .I_vs(I_vs), .I_vs_pol(I_vs_pol),
    .I_data_r(I_data_r), .I_data_g(I_data_g), .I_data_b(I_data_b),
    .I_key_r(I_key_r), .I_key_g(I_key_g), .I_key_b(I_key_b), .I_tol(I_tol),
    .O_bbox_valid(O_bbox_valid), .O_found(O_found),
    .O_x_min(O_x_min), .O_x_max(O_x_max), .O_y_min(O_y_min), .O_y_max(O_y_max),
    .O_pix_cnt(O_pix_cnt)
  );

  always #5 I_pxl_clk = ~I_pxl_clk;

  int cyc = 0;
  always @(posedge I_pxl_clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int pulses = 0;
  int pulse_cyc = 0;
  always @(negedge I_pxl_clk) begin
    if (O_bbox_valid) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scene: black background with one coloured rectangle.
  int          rx0, rx1, ry0, ry1;
  logic [23:0] rcol;
  int          vs_cyc;

  task automatic step();
    @(posedge I_pxl_clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic vs_active);
    for (int i = 0; i < n; i++) begin
      I_de = 1'b0;
      {I_data_r, I_data_g, I_data_b} = 24'h0;
      I_vs = vs_active ? I_vs_pol : ~I_vs_pol;
      if (vs_active && i == 0) vs_cyc = cyc;
      step();
    end
  endtask

  // Active lines first, then vertical blanking with the VS pulse that ends the frame.
  task automatic run_frame(input int rst_line);
    for (int y = 0; y < H; y++) begin
      if (y == rst_line) begin
        I_rst = 1'b1;
        step();
        I_rst = 1'b0;
      end
      for (int x = 0; x < W; x++) begin
        I_de = 1'b1;
        I_vs = ~I_vs_pol;
        if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1)
          {I_data_r, I_data_g, I_data_b} = rcol;
        else
          {I_data_r, I_data_g, I_data_b} = 24'h0;
        step();
      end
      idle_cycles(HB, 1'b0);
    end
    idle_cycles(2 * LL, 1'b0);
    idle_cycles(LL, 1'b1);
    idle_cycles(2 * LL, 1'b0);
  endtask

  task automatic frame_and_check(input string tag, input int rst_line, input int exp_pulses,
                                 input logic exp_found, input int xmin, input int xmax,
                                 input int ymin, input int ymax, input int cnt);
    int p0;
    p0 = pulses;
    run_frame(rst_line);
    chk({tag, ".pulses"}, pulses - p0, exp_pulses);
    if (exp_pulses == 1) chk({tag, ".latency"}, pulse_cyc - vs_cyc, 4);
    chk({tag, ".found"}, O_found, exp_found);
    chk({tag, ".x_min"}, O_x_min, xmin);
    chk({tag, ".x_max"}, O_x_max, xmax);
    chk({tag, ".y_min"}, O_y_min, ymin);
    chk({tag, ".y_max"}, O_y_max, ymax);
    chk({tag, ".cnt"}, O_pix_cnt, cnt);
  endtask

  task automatic set_key(input logic [23:0] key, input logic [7:0] tol);
    {I_key_r, I_key_g, I_key_b} = key;
    I_tol = tol;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1,
                          input logic [23:0] col);
    rx0 = x0; rx1 = x1; ry0 = y0; ry1 = y1; rcol = col;
  endtask

  initial begin
    I_rst = 1'b1; I_de = 1'b0; I_vs_pol = 1'b0; I_vs = 1'b1;
    {I_data_r, I_data_g, I_data_b} = 24'h0;
    set_key(24'h000000, 8'd0);
    set_rect(1, 0, 1, 0, 24'h0);
    vs_cyc = 0;
    repeat (4) step();
    chk("rst.valid", O_bbox_valid, 0);
    chk("rst.found", O_found, 0);
    chk("rst.x_max", O_x_max, 0);
    chk("rst.y_max", O_y_max, 0);
    chk("rst.cnt", O_pix_cnt, 0);
    I_rst = 1'b0;
    step();

    // All-black frames with a black key: every active pixel matches.
    frame_and_check("blk1", -1, 0, 1'b0, 0, 0, 0, 0, 0);
    frame_and_check("blk2", -1, 1, 1'b1, 0, 63, 0, 31, 2048);
    frame_and_check("blk3", -1, 1, 1'b1, 0, 63, 0, 31, 2048);

    // Red 10x8 square.
    set_key(24'hFF0000, 8'd8);
    set_rect(20, 29, 5, 12, 24'hFF0000);
    frame_and_check("red10x8", -1, 1, 1'b1, 20, 29, 5, 12, 80);

    // 3x3 square is below the minimum count.
    set_rect(20, 22, 5, 7, 24'hFF0000);
    frame_and_check("red3x3", -1, 1, 1'b0, 0, 0, 0, 0, 9);

    // FB0404 against FF0000: distance 4 per channel; black must stay at 255.
    set_key(24'hFF0000, 8'd4);
    set_rect(40, 44, 20, 24, 24'hFB0404);
    frame_and_check("tol4", -1, 1, 1'b1, 40, 44, 20, 24, 25);
    set_key(24'hFF0000, 8'd3);
    frame_and_check("tol3", -1, 1, 1'b0, 0, 0, 0, 0, 0);

    // Inverted VS with polarity 1: polarity and level flip together.
    I_vs_pol = 1'b1;
    I_vs = 1'b0;
    set_key(24'hFF0000, 8'd8);
    set_rect(20, 29, 5, 12, 24'hFF0000);
    frame_and_check("pol1", -1, 1, 1'b1, 20, 29, 5, 12, 80);

    // Reset at line 10: that frame only re-arms, the next one reports.
    frame_and_check("rstmid", 10, 0, 1'b0, 0, 0, 0, 0, 0);
    frame_and_check("after", -1, 1, 1'b1, 20, 29, 5, 12, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
